// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of an asynchronous PWM input and
// reports duty in tenths. Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample stability filter.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [3:0]       duty_tenths,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic             meas_valid,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic             sync1, sync2, s, s_d;
  logic             rise, fall, timeout_hit, capture;
  logic [CNT_W-1:0] cnt, cnt_next, hi_snap, hi_next, gap;

  logic             calc_busy;
  logic [1:0]       bit_idx;
  logic [CNT_W+3:0] num, num_init, shifted;
  logic [CNT_W-1:0] divisor, hi_hold;
  logic [3:0]       quo, q_new;
  logic             take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      s_d   <= s;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic h1, h2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      h1 <= sync2;
      h2 <= h1;
    end
  end

  // s follows the synchroniser only once three consecutive samples agree
  assign s = (sync2 == h1 && h1 == h2) ? sync2 : s_d;
`else
  assign s = sync2;
`endif

  assign rise        = s & ~s_d;
  assign fall        = ~s & s_d;
  assign timeout_hit = !(rise || fall) && (gap == TO_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap <= '0;
    end else if (rise || fall) begin
      gap <= '0;
    end else if (gap != TO_VAL) begin
      gap <= gap + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_snap <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hi_snap <= hi_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hi_next    = hi_snap;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          cnt_next   = CNT_W'(1);
          state_next = HIGH;
        end
      end
      HIGH: begin
        cnt_next = cnt + 1'b1;
        if (fall) begin
          hi_next    = cnt;
          state_next = LOW;
        end
      end
      LOW: begin
        cnt_next = cnt + 1'b1;
        if (rise) begin
          capture    = 1'b1;
          cnt_next   = CNT_W'(1);
          state_next = HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = IDLE;
      cnt_next   = '0;
      capture    = 1'b0;
    end
  end

  // Rounded quotient (10*hi + period/2) / period, one restoring step per cycle
  assign num_init = ({4'b0000, hi_snap} << 3) + ({4'b0000, hi_snap} << 1)
                  + {5'b00000, cnt[CNT_W-1:1]};
  assign shifted  = {4'b0000, divisor} << bit_idx;
  assign take     = (num >= shifted);
  assign q_new    = quo | (take ? (4'b0001 << bit_idx) : 4'b0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      calc_busy    <= 1'b0;
      bit_idx      <= 2'd0;
      num          <= '0;
      divisor      <= '0;
      hi_hold      <= '0;
      quo          <= 4'd0;
      duty_tenths  <= 4'd0;
      high_count   <= '0;
      period_count <= '0;
      meas_valid   <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) stuck <= 1'b0;
      if (timeout_hit) begin
        calc_busy    <= 1'b0;
        stuck        <= 1'b1;
        period_count <= '0;
        high_count   <= '0;
        duty_tenths  <= s ? 4'd10 : 4'd0;
        meas_valid   <= 1'b1;
      end else if (calc_busy) begin
        num     <= take ? (num - shifted) : num;
        quo     <= q_new;
        bit_idx <= bit_idx - 2'd1;
        if (bit_idx == 2'd0) begin
          calc_busy    <= 1'b0;
          high_count   <= hi_hold;
          period_count <= divisor;
          duty_tenths  <= (q_new > 4'd10) ? 4'd10 : q_new;
          meas_valid   <= 1'b1;
        end
      end else if (capture) begin
        // A capture arriving while busy is simply not accepted
        calc_busy <= 1'b1;
        num       <= num_init;
        divisor   <= cnt;
        hi_hold   <= hi_snap;
        quo       <= 4'd0;
        bit_idx   <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed, table-driven bench for pwm_capture (both with and without PWM_CAPTURE_GLITCH_FILTER_EN).
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 200;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT     = 9;
  localparam int GL_HIGH = 5, GL_PERIOD = 10, GL_DUTY = 5;
`else
  localparam int LAT     = 7;
  localparam int GL_HIGH = 5, GL_PERIOD = 7, GL_DUTY = 7;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm_in;
  logic [3:0]       duty_tenths;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             meas_valid;
  logic             stuck;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .duty_tenths  (duty_tenths),
    .high_count   (high_count),
    .period_count (period_count),
    .meas_valid   (meas_valid),
    .stuck        (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned high;
    int unsigned period;
    int unsigned duty;
    int unsigned stk;
    int unsigned cyc;
  } res_t;

  typedef struct {
    int hi;
    int per;
    int reps;
    int exp_high;
    int exp_period;
    int exp_duty;
    int exp_gap;
  } vec_t;

  int unsigned cyc = 0;
  res_t        results[$];
  int unsigned rises[$];
  res_t        mon_r;
  int          passed = 0;
  int          total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every valid pulse is logged with the cycle it was seen in
  always @(negedge clk) begin
    if (meas_valid) begin
      mon_r.high   = high_count;
      mon_r.period = period_count;
      mon_r.duty   = duty_tenths;
      mon_r.stk    = stuck;
      mon_r.cyc    = cyc;
      results.push_back(mon_r);
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input int hi, input int per, input int reps);
    for (int r = 0; r < reps; r++) begin
      pwm_in = 1'b1;
      rises.push_back(cyc);
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (per - hi) @(negedge clk);
    end
  endtask

  task automatic hold_low(input int n);
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_duty"}, duty_tenths, 0);
    check_output({tag, "_high"}, high_count, 0);
    check_output({tag, "_period"}, period_count, 0);
    check_output({tag, "_valid"}, meas_valid, 0);
    check_output({tag, "_stuck"}, stuck, 0);
  endtask

  task automatic check_result(input string tag, input res_t r, input int h, input int p, input int d);
    check_output({tag, "_high"}, r.high, h);
    check_output({tag, "_period"}, r.period, p);
    check_output({tag, "_duty"}, r.duty, d);
  endtask

  initial begin
    vec_t vecs[9];
    int   k;
    int   n;
    int   n0;
    int   sz;

    vecs[0] = '{5, 10, 3, 5, 10, 5, 10};
    vecs[1] = '{6, 10, 3, 6, 10, 6, 10};
    vecs[2] = '{9, 10, 3, 9, 10, 9, 10};
    vecs[3] = '{3, 7, 3, 3, 7, 4, 7};
    vecs[4] = '{1, 20, 3, 1, 20, 1, 20};
    vecs[5] = '{1, 21, 3, 1, 21, 0, 21};
    vecs[6] = '{19, 20, 3, 19, 20, 10, 20};
    vecs[7] = '{2, 4, 6, 2, 4, 5, 8};
    vecs[8] = '{1, 2, 8, 1, 2, 5, 6};

    reset  = 1'b1;
    pwm_in = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Default waveform: first rise only starts a measurement, then one result per period
    results.delete();
    rises.delete();
    apply_stimulus(5, 10, 4);
    check_output("seqA_count", results.size(), 3);
    for (int i = 0; i < 3 && i < results.size(); i++) begin
      check_result($sformatf("seqA%0d", i), results[i], 5, 10, 5);
      check_output($sformatf("seqA%0d_stuck", i), results[i].stk, 0);
      check_output($sformatf("seqA%0d_lat", i), results[i].cyc - rises[i+1], LAT);
    end

    for (int i = 0; i < 9; i++) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (vecs[i].hi < 3 || vecs[i].per - vecs[i].hi < 3) continue;
`endif
      results.delete();
      apply_stimulus(vecs[i].hi, vecs[i].per, vecs[i].reps);
      hold_low(8);
      sz = results.size();
      check_output($sformatf("v%0d_count", i), sz >= 2, 1);
      if (sz >= 2) begin
        check_result($sformatf("v%0d", i), results[sz-1], vecs[i].exp_high, vecs[i].exp_period, vecs[i].exp_duty);
        check_output($sformatf("v%0d_spacing", i), results[sz-1].cyc - results[sz-2].cyc, vecs[i].exp_gap);
      end
    end

    // Input stuck high, then stuck low, then recovery
    apply_stimulus(5, 10, 2);
    results.delete();
    pwm_in = 1'b1;
    k = cyc;
    n = 0;
    while (results.size() < 2 && n < TIMEOUT + 40) begin
      @(negedge clk);
      n++;
    end
    check_output("toH_seen", results.size() >= 2, 1);
    if (results.size() >= 2) begin
      check_output("toH_prev_high", results[0].high, 5);
      check_result("toH", results[1], 0, 0, 10);
      check_output("toH_stuck", results[1].stk, 1);
      check_output("toH_time", results[1].cyc - k, TIMEOUT + LAT - 4);
    end
    repeat (50) @(negedge clk);
    check_output("toH_no_repeat", results.size(), 2);
    check_output("toH_stuck_level", stuck, 1);

    pwm_in = 1'b0;
    k = cyc;
    n = 0;
    while (results.size() < 3 && n < TIMEOUT + 40) begin
      @(negedge clk);
      n++;
    end
    check_output("toL_seen", results.size() >= 3, 1);
    if (results.size() >= 3) begin
      check_result("toL", results[2], 0, 0, 0);
      check_output("toL_stuck", results[2].stk, 1);
      check_output("toL_time", results[2].cyc - k, TIMEOUT + LAT - 4);
    end

    results.delete();
    rises.delete();
    apply_stimulus(5, 10, 3);
    check_output("recover_stuck", stuck, 0);
    check_output("recover_count", results.size(), 2);
    if (results.size() >= 1) begin
      check_result("recover", results[0], 5, 10, 5);
      check_output("recover_time", results[0].cyc - rises[1], LAT);
    end

    // Asynchronous reset in the high phase
    apply_stimulus(5, 10, 2);
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    check_output("preRst_high", high_count, 5);
    #2 reset = 1'b0;
    #1 check_zero("rstH");
    pwm_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold_low(3);

    // Asynchronous reset while the divider is working
    results.delete();
    rises.delete();
    apply_stimulus(5, 10, 2);
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    n0 = results.size();
    #2 reset = 1'b0;
    #1 check_zero("rstC");
    pwm_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold_low(10);
    check_output("rstC_no_valid", results.size(), n0);

    results.delete();
    rises.delete();
    apply_stimulus(5, 10, 3);
    check_output("postRst_count", results.size(), 2);
    if (results.size() >= 1) begin
      check_result("postRst", results[0], 5, 10, 5);
      check_output("postRst_time", results[0].cyc - rises[1], LAT);
    end

    // One-cycle spike inside the low phase
    apply_stimulus(5, 10, 2);
    results.delete();
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pwm_in = 1'b1;
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    apply_stimulus(5, 10, 2);
    hold_low(8);
    check_output("glitch_count", results.size() >= 2, 1);
    if (results.size() >= 2) check_result("glitch", results[1], GL_HIGH, GL_PERIOD, GL_DUTY);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
